acc_long: RTL and testbench

- Sequential saturating accumulator placed directly downstream of the integer sign-extension stage.
- Consumes a stream of signed terms already widened to long precision, plus a per-vector bias.
- Sums a fixed number of terms per vector and emits one long-precision result per vector with a valid/ready handshake.
- Forms the reduction stage of the perceptron datapath, ahead of the activation block.

---
 rtl/acc_long.sv | 150 +++++++++++++++
 tb/tb_acc_long.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_long.sv
// acc_long: sequential saturating accumulator for the perceptron reduction stage.
// Sums DEPTH widened terms per vector. The first term of each vector is added
// to a per-vector bias. Each partial sum is clamped to the PREC-bit range. One
// result per vector is presented on a valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   reset_     asynchronous active-low reset
//   clear      synchronous abort of the current vector (wins over in_valid/out_ready)
//   in_valid   in_data carries a valid term
//   in_ready   block accepts a term this cycle (high while accumulating)
//   in_data    widened term, PREC bits
//   bias       vector bias, sampled only with the first term of a vector
//   out_valid  out_data/out_ovf hold a completed result
//   out_ready  consumer accepts the result
//   out_data   saturated accumulated sum (registered)
//   out_ovf    sticky saturation flag for the vector (registered)
module acc_long #(
  parameter int unsigned PREC  = 32,
  parameter int unsigned DEPTH = 8,
  parameter bit          SIGN  = 1'b1,
  parameter int unsigned CNT_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PREC-1:0] in_data,
  input  logic [PREC-1:0] bias,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PREC-1:0] out_data,
  output logic            out_ovf
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [PREC-1:0]  SMIN = {1'b1, {(PREC-1){1'b0}}};
  localparam logic [PREC-1:0]  SMAX = {1'b0, {(PREC-1){1'b1}}};

  state_t          state;
  state_t          next_state;
  logic [PREC-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic            ovf;

  logic            take;
  logic [PREC-1:0] add_a;
  logic [PREC:0]   ext_a;
  logic [PREC:0]   ext_b;
  logic [PREC:0]   sum;
  logic            sat_flag;
  logic [PREC-1:0] sat_val;

  // Adder: the first term of a vector pairs with the bias instead of acc, so
  // acc never needs to be preloaded between vectors.
  always_comb begin
    add_a = (cnt == '0) ? bias : acc;
    if (SIGN) begin
      ext_a = {add_a[PREC-1], add_a};
      ext_b = {in_data[PREC-1], in_data};
    end else begin
      ext_a = {1'b0, add_a};
      ext_b = {1'b0, in_data};
    end
    sum = ext_a + ext_b;
    if (SIGN) begin
      // Signed overflow shows as disagreement between the guard bit and the MSB.
      sat_flag = sum[PREC] ^ sum[PREC-1];
      if (sat_flag) begin
        sat_val = sum[PREC] ? SMIN : SMAX;
      end else begin
        sat_val = sum[PREC-1:0];
      end
    end else begin
      sat_flag = sum[PREC];
      sat_val  = sat_flag ? '1 : sum[PREC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ACC;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        take     = in_valid & ~clear;
        if (take && (cnt == LAST)) begin
          next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (clear || out_ready) begin
          next_state = ACC;
        end
      end
      default: next_state = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (state == ACC) begin
      if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take) begin
        acc <= sat_val;
        ovf <= ovf | sat_flag;
        if (cnt == LAST) begin
          // The result is captured straight from the adder so the output
          // registers change only when a vector completes.
          cnt      <= '0;
          out_data <= sat_val;
          out_ovf  <= ovf | sat_flag;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      if (clear || out_ready) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_long.sv
// Bench for acc_long: two instances (signed and unsigned, PREC=8, DEPTH=4)
// share one stimulus stream and are checked every cycle against a vector-level
// integer model. Directed vectors carry hand-computed literal results.
module tb_acc_long;

  localparam int PREC  = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] bias = '0;
  logic       out_ready = 1'b0;

  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [7:0] s_out_data;
  logic       u_in_ready, u_out_valid, u_out_ovf;
  logic [7:0] u_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_long #(.PREC(PREC), .DEPTH(DEPTH), .SIGN(1'b1)) u_s (
    .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data), .bias(bias),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  acc_long #(.PREC(PREC), .DEPTH(DEPTH), .SIGN(1'b0)) u_u (
    .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid),
    .in_ready(u_in_ready), .in_data(in_data), .bias(bias),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_ovf(u_out_ovf)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: index 0 = signed instance, 1 = unsigned instance.
  bit     m_busy [2];   // result pending
  longint m_sum  [2];
  int     m_cnt  [2];
  bit     m_ovf  [2];
  longint m_res  [2];
  bit     m_rovf [2];

  function automatic longint val(input int m, input logic [7:0] x);
    if (m == 0) return longint'($signed(x));
    return longint'(x);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_sum[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0;
      m_res[m] = 0; m_rovf[m] = 0;
    end
  endtask

  task automatic model_step();
    longint lo, hi, s;
    for (int m = 0; m < 2; m++) begin
      lo = (m == 0) ? -128 : 0;
      hi = (m == 0) ? 127 : 255;
      if (m_busy[m]) begin
        if (clear || out_ready) begin
          m_busy[m] = 0; m_sum[m] = 0; m_ovf[m] = 0;
        end
      end else if (clear) begin
        m_sum[m] = 0; m_cnt[m] = 0; m_ovf[m] = 0;
      end else if (in_valid) begin
        s = ((m_cnt[m] == 0) ? val(m, bias) : m_sum[m]) + val(m, in_data);
        if (s > hi) begin s = hi; m_ovf[m] = 1; end
        if (s < lo) begin s = lo; m_ovf[m] = 1; end
        m_sum[m] = s;
        m_cnt[m]++;
        if (m_cnt[m] == DEPTH) begin
          m_cnt[m] = 0; m_busy[m] = 1; m_res[m] = s; m_rovf[m] = m_ovf[m];
        end
      end
    end
  endtask

  // Per-cycle comparison; also reacts to asynchronous reset assertion.
  always @(posedge clk or negedge reset_) begin
    logic [7:0] e;
    if (!reset_) model_reset();
    else model_step();
    #1;
    chk("s_in_ready", s_in_ready, !m_busy[0]);
    chk("s_out_valid", s_out_valid, m_busy[0]);
    chk("u_in_ready", u_in_ready, !m_busy[1]);
    chk("u_out_valid", u_out_valid, m_busy[1]);
    if (m_busy[0]) begin
      e = m_res[0][7:0];
      chk("s_out_data", s_out_data, e);
      chk("s_out_ovf", s_out_ovf, m_rovf[0]);
    end
    if (m_busy[1]) begin
      e = m_res[1][7:0];
      chk("u_out_data", u_out_data, e);
      chk("u_out_ovf", u_out_ovf, m_rovf[1]);
    end
  end

  // Called right after a negedge; leaves the bench on the following negedge.
  task automatic push(input logic [7:0] b, input logic [7:0] d, input bit gap);
    in_valid = 1'b1; in_data = d; bias = b;
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  // Later terms carry a junk bias to show only the first one is sampled.
  task automatic vec4(input logic [7:0] b, input logic [7:0] t0, input logic [7:0] t1,
                      input logic [7:0] t2, input logic [7:0] t3, input bit gap);
    push(b, t0, gap);
    push(~b, t1, gap);
    push(~b, t2, gap);
    push(~b, t3, 1'b0);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_take", s_in_ready, 1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, s_in_ready, 1);
    chk({nm, "_out_valid"}, s_out_valid, 0);
    chk({nm, "_out_data"}, s_out_data, 0);
    chk({nm, "_out_ovf"}, s_out_ovf, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    check_reset_vals("reset");

    // Basic: 5+1+2+3-10 = 1, valid right after the 4th accept.
    vec4(8'd5, 8'd1, 8'd2, 8'd3, 8'hF6, 1'b0);
    chk("basic_valid", s_out_valid, 1);
    chk("basic_data", s_out_data, 1);
    chk("basic_ovf", s_out_ovf, 0);
    take();

    // Positive clamp at 127, then 77.
    vec4(8'd0, 8'd100, 8'd100, 8'hCE, 8'd0, 1'b0);
    chk("pos_sat_data", s_out_data, 77);
    chk("pos_sat_ovf", s_out_ovf, 1);
    take();
    vec4(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("ovf_cleared_data", s_out_data, 4);
    chk("ovf_cleared_ovf", s_out_ovf, 0);
    take();

    // Negative clamp.
    vec4(8'd0, 8'h80, 8'hFF, 8'd0, 8'd0, 1'b0);
    chk("neg_sat_data", s_out_data, 8'h80);
    chk("neg_sat_ovf", s_out_ovf, 1);
    take();

    // Unsigned carry clamp.
    vec4(8'd0, 8'd200, 8'd100, 8'd0, 8'd0, 1'b0);
    chk("uns_sat_data", u_out_data, 255);
    chk("uns_sat_ovf", u_out_ovf, 1);
    take();

    // Gaps in input, then backpressure for 5 cycles.
    vec4(8'd3, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", s_out_data, 103);
      chk("bp_in_ready", s_in_ready, 0);
      @(negedge clk);
    end
    take();
    chk("bp_valid_after_take", s_out_valid, 0);

    // clear with the 3rd term drops it and the partial sum.
    push(8'd0, 8'd5, 1'b0);
    push(8'd0, 8'd5, 1'b0);
    in_valid = 1'b1; in_data = 8'd50; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    vec4(8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("clear_acc_data", s_out_data, 6);
    // clear in OUT with out_ready: result discarded, back to accepting.
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    chk("clear_out_valid", s_out_valid, 0);
    chk("clear_out_in_ready", s_in_ready, 1);
    vec4(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    chk("after_clear_data", s_out_data, 4);
    take();

    // Asynchronous reset mid-vector and in OUT.
    push(8'd9, 8'd9, 1'b0);
    push(8'd9, 8'd9, 1'b0);
    #2 reset_ = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    reset_ = 1'b1;
    vec4(8'd0, 8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
    #2 reset_ = 1'b0;
    #1 check_reset_vals("rst_out");
    @(negedge clk);
    reset_ = 1'b1;
    vec4(8'd1, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
    chk("post_reset_data", s_out_data, 29);
    chk("post_reset_ovf", s_out_ovf, 0);
    take();

    // Randomized traffic checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      reset_    = 1'b1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      bias      = 8'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      clear     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) #2 reset_ = 1'b0;
      @(negedge clk);
    end
    reset_ = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
